// File: rtl/router_fsm.sv
// router_fsm: input-side control FSM of the 1x3 router.
// Decodes the destination address of each packet, then sequences the
// header, payload and parity bytes into the selected output FIFO while
// telling the sender when it must hold its current byte.
module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] addr;

  logic       hdr_empty;
  logic       addr_empty;
  logic       soft_reset_sel;

  // Empty flag of the port named by the incoming header byte; address 3 has no port.
  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  // Empty flag and soft reset of the port latched for the packet in flight.
  always_comb begin
    addr_empty     = 1'b0;
    soft_reset_sel = 1'b0;
    case (addr)
      2'd0: begin
        addr_empty     = fifo_empty_0;
        soft_reset_sel = soft_reset_0;
      end
      2'd1: begin
        addr_empty     = fifo_empty_1;
        soft_reset_sel = soft_reset_1;
      end
      2'd2: begin
        addr_empty     = fifo_empty_2;
        soft_reset_sel = soft_reset_2;
      end
      default: begin
        addr_empty     = 1'b0;
        soft_reset_sel = 1'b0;
      end
    endcase
  end

  // State register and destination latch; the header address is captured while decoding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= next_state;
      if (state == DECODE_ADDRESS && pkt_valid)
        addr <= data_in;
    end
  end

  // Next-state logic; a soft reset on the selected port abandons the packet.
  always_comb begin
    next_state = DECODE_ADDRESS;
    if (soft_reset_sel) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != 2'd3)
            next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          else
            next_state = DECODE_ADDRESS;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)
            next_state = FIFO_FULL_STATE;
          else if (!pkt_valid)
            next_state = LOAD_PARITY;
          else
            next_state = LOAD_DATA;
        end
        FIFO_FULL_STATE: next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)
            next_state = DECODE_ADDRESS;
          else if (low_pkt_valid)
            next_state = LOAD_PARITY;
          else
            next_state = LOAD_DATA;
        end
        LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:    next_state = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:            next_state = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore outputs decoded from the registered state only, so lfd_state is a clean pulse.
  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_AFTER_FULL) ||
                    (state == LOAD_PARITY);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
Control state machine for the 1x3 router input side. It decodes the 2-bit destination address of each incoming packet and sequences header, payload and parity loading into the selected output FIFO. It also drives the FIFO write enable, the first-data marker and the sender-facing busy flag. It sits upstream of the three output FIFOs and the input register/parity block, and consumes FIFO status and synchronizer soft resets.

Parameters:
none (address width fixed at 2, three destination ports fixed)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  sender drives valid packet byte
data_in  input  2  destination address, bits [1:0] of header byte
parity_done  input  1  parity byte captured by register block
low_pkt_valid  input  1  register block saw pkt_valid fall while FIFO full
fifo_full  input  1  full flag of currently selected FIFO (muxed by synchronizer)
fifo_empty_0  input  1  empty flag, FIFO 0
fifo_empty_1  input  1  empty flag, FIFO 1
fifo_empty_2  input  1  empty flag, FIFO 2
soft_reset_0  input  1  timeout soft reset, port 0
soft_reset_1  input  1  timeout soft reset, port 1
soft_reset_2  input  1  timeout soft reset, port 2
busy  output  1  sender must hold current byte
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
write_enb_reg  output  1  FIFO write request
rst_int_reg  output  1  in CHECK_PARITY_ERROR, clears internal parity regs

Behaviour:
- Moore FSM, 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY. State register updates on posedge clk.
- Reset: resetn=0 at a posedge forces DECODE_ADDRESS and clears the address latch to 0. This applies in any state, including mid-packet. After reset, detect_add=1 and all other outputs are 0.
- Address latch (addr, 2 bits): loads data_in when state==DECODE_ADDRESS and pkt_valid=1. Holds otherwise.
- Soft reset: if soft_reset_k=1 and addr==k, next state is DECODE_ADDRESS. This has priority over every transition below except resetn. soft_reset of a non-selected port is ignored.
- DECODE_ADDRESS:
  - pkt_valid=1, data_in=k (k in 0..2), fifo_empty_k=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in=k, fifo_empty_k=0 -> WAIT_TILL_EMPTY.
  - data_in=3 or pkt_valid=0 -> stay. Address 3 packets are dropped.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditional, 1 cycle.
- LOAD_DATA:
  - fifo_full=1 -> FIFO_FULL_STATE.
  - fifo_full=0 and pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done=1 -> DECODE_ADDRESS.
  - parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
  - parity_done=0, low_pkt_valid=0 -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR, unconditional.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty of latched addr =1 -> LOAD_FIRST_DATA; else stay.
- Outputs, decoded from current state only (no input paths):
  - detect_add = DECODE_ADDRESS.
  - lfd_state = LOAD_FIRST_DATA.
  - ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL.
  - full_state = FIFO_FULL_STATE.
  - rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_AFTER_FULL | LOAD_PARITY.
  - busy = 1 in all states except DECODE_ADDRESS and LOAD_DATA.
- The FIFO registers lfd_state one cycle internally, so lfd_state must be a clean 1-cycle pulse per packet, never glitching.
- Illegal state encodings recover to DECODE_ADDRESS on the next clock.

Test Plan:
- Reset: hold resetn=0 for 2 clk from arbitrary state -> state DECODE_ADDRESS, detect_add=1, busy=0, write_enb_reg=0.
- Normal packet to port 1, all FIFOs empty: pkt_valid=1, data_in=2'b01, then 4 payload cycles, then pkt_valid=0 -> sequence DECODE, LFD(1 cyc, busy=1), LOAD_DATA x4 (write_enb_reg=1, busy=0), LOAD_PARITY, CHECK_PARITY_ERROR (rst_int_reg=1), DECODE.
- Busy port: fifo_empty_2=0, header data_in=2'b10 -> WAIT_TILL_EMPTY with busy=1. Raise fifo_empty_2 -> LOAD_FIRST_DATA next cycle.
- Full during payload: fifo_full=1 in LOAD_DATA -> FIFO_FULL_STATE, write_enb_reg=0, busy=1. Drop fifo_full with low_pkt_valid=0 -> LOAD_AFTER_FULL, then LOAD_DATA. Repeat with low_pkt_valid=1 -> LOAD_PARITY.
- Soft reset: mid-payload to port 0, pulse soft_reset_0 -> DECODE_ADDRESS next cycle. soft_reset_1 pulse in the same situation -> no effect.
- Address 3: pkt_valid=1, data_in=2'b11 for 5 cycles -> stays DECODE_ADDRESS, write_enb_reg=0 throughout.
